// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the display fetch path
// and a pixel-writer requester. The display always wins a free cycle; the
// writer gets whatever is left through a req/ack handshake. All RAM-facing
// outputs are registered so the RAM sees clean, glitch-free control.
module vram_arbiter #(
  parameter int DATA_W = 8,
  parameter int X_MAX  = 127,
  parameter int Y_MAX  = 95
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        x_pixel,
  input  logic [6:0]        y_pixel,
  input  logic              video_on,
  input  logic              wr_req,
  input  logic [6:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [13:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid
);

  // Coordinate limits narrowed to the port width so the range compare is
  // a plain 7-bit comparison.
  localparam logic [6:0] X_LIM = 7'(X_MAX);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [13:0]         last_coord_q, last_coord_d;
  logic                last_valid_q, last_valid_d;
  logic                capture_q, capture_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [13:0]         ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic [DATA_W-1:0]   pixel_data_q, pixel_data_d;
  logic                pixel_valid_q, pixel_valid_d;

  logic [13:0]         disp_coord;
  logic                disp_pend;
  logic                wr_oob;

  // A fetch is owed whenever the display is live and the cell it shows is
  // not the one last fetched (or nothing has been fetched since reset).
  always_comb begin
    disp_coord = {y_pixel, x_pixel};
    disp_pend  = video_on && (!last_valid_q || (disp_coord != last_coord_q));
    wr_oob     = (wr_x > X_LIM) || (wr_y > Y_LIM);
  end

  // Arbitration FSM: every access state lasts one cycle and falls back to
  // IDLE, which keeps ram_en from ever being high two cycles running and
  // spaces writer acks at least two cycles apart.
  always_comb begin
    state_d      = IDLE;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wr_ack_d     = 1'b0;
    wr_err_d     = 1'b0;
    last_coord_d = last_coord_q;
    last_valid_d = last_valid_q;
    case (state_q)
      IDLE: begin
        if (disp_pend) begin
          state_d      = READ;
          ram_en_d     = 1'b1;
          ram_addr_d   = disp_coord;
          last_coord_d = disp_coord;
          last_valid_d = 1'b1;
        end else if (wr_req) begin
          state_d  = WRITE;
          wr_ack_d = 1'b1;
          if (wr_oob) begin
            wr_err_d = 1'b1;
          end else begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = {wr_y, wr_x};
            ram_wdata_d = wr_data;
          end
        end
      end
      READ:    state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel path: capture read data the cycle after a READ, but drop it (and
  // anything already shown) as soon as the display blanks.
  always_comb begin
    capture_d     = (state_q == READ) && video_on;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    if (!video_on) begin
      pixel_data_d  = '0;
      pixel_valid_d = 1'b0;
    end else if (capture_q) begin
      pixel_data_d  = ram_rdata;
      pixel_valid_d = 1'b1;
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_coord_q  <= '0;
      last_valid_q  <= 1'b0;
      capture_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_coord_q  <= last_coord_d;
      last_valid_q  <= last_valid_d;
      capture_q     <= capture_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      wr_ack_q      <= wr_ack_d;
      wr_err_q      <= wr_err_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign wr_ack      = wr_ack_q;
  assign wr_err      = wr_err_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a small behavioural VRAM sits on the RAM port,
// a table of per-cycle vectors covers fetch/collision/range cases, and
// hand-written sequences cover reset, blanking and held coordinates.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  x_pixel = '0;
  logic [6:0]  y_pixel = '0;
  logic        video_on = 1'b0;
  logic        wr_req = 1'b0;
  logic [6:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        wr_err;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [7:0]  pixel_data;
  logic        pixel_valid;

  logic [7:0]  mem [0:16383] = '{default: 8'h00};
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  int tests_run = 0;
  int tests_failed = 0;

  vram_arbiter #(.DATA_W(8), .X_MAX(127), .Y_MAX(95)) dut (
    .clk(clk), .rst(rst),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .video_on(video_on),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a backdoor write port for preloading.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        vo;
    logic [6:0]  x, y;
    logic        req;
    logic [6:0]  wx, wy;
    logic [7:0]  wd;
    logic        e_en, e_we;
    logic [13:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_ack, e_err, e_pv;
    logic [7:0]  e_pd;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic vo, input logic [6:0] x, input logic [6:0] y,
                              input logic req, input logic [6:0] wx, input logic [6:0] wy,
                              input logic [7:0] wd, input logic e_en, input logic e_we,
                              input logic [13:0] e_addr, input logic [7:0] e_wd,
                              input logic e_ack, input logic e_err, input logic e_pv,
                              input logic [7:0] e_pd);
    vec_t v;
    v.vo = vo; v.x = x; v.y = y; v.req = req; v.wx = wx; v.wy = wy; v.wd = wd;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_ack = e_ack; v.e_err = e_err; v.e_pv = e_pv; v.e_pd = e_pd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vo, input logic [6:0] x, input logic [6:0] y,
                               input logic req, input logic [6:0] wx, input logic [6:0] wy,
                               input logic [7:0] wd);
    video_on = vo; x_pixel = x; y_pixel = y;
    wr_req = req; wr_x = wx; wr_y = wy; wr_data = wd;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ram_en"}, 32'(ram_en), 32'd0);
    checkOutput({tag, " ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, " wr_ack"}, 32'(wr_ack), 32'd0);
    checkOutput({tag, " wr_err"}, 32'(wr_err), 32'd0);
    checkOutput({tag, " pixel_data"}, 32'(pixel_data), 32'd0);
    checkOutput({tag, " pixel_valid"}, 32'(pixel_valid), 32'd0);
  endtask

  initial begin
    int n;
    int reads;

    // Per-cycle vectors: inputs applied in a cycle, expected outputs are
    // those visible during that same cycle (all outputs are registered).
    vecs[0]  = mk(1, 10, 5, 0, 0, 0, 8'h00,  0, 0, 14'h000, 8'h00, 0, 0, 1, 8'h42);
    vecs[1]  = mk(1, 10, 5, 0, 0, 0, 8'h00,  1, 0, 14'h28A, 8'h00, 0, 0, 1, 8'h42);
    vecs[2]  = mk(1, 10, 5, 0, 0, 0, 8'h00,  0, 0, 14'h28A, 8'h00, 0, 0, 1, 8'h42);
    vecs[3]  = mk(1, 10, 5, 0, 0, 0, 8'h00,  0, 0, 14'h28A, 8'h00, 0, 0, 1, 8'hA5);
    vecs[4]  = mk(1, 11, 5, 1, 3, 2, 8'h3C,  0, 0, 14'h28A, 8'h00, 0, 0, 1, 8'hA5);
    vecs[5]  = mk(1, 11, 5, 1, 3, 2, 8'h3C,  1, 0, 14'h28B, 8'h00, 0, 0, 1, 8'hA5);
    vecs[6]  = mk(1, 11, 5, 1, 3, 2, 8'h3C,  0, 0, 14'h28B, 8'h00, 0, 0, 1, 8'hA5);
    vecs[7]  = mk(1, 11, 5, 1, 3, 2, 8'h3C,  1, 1, 14'h103, 8'h3C, 1, 0, 1, 8'h5B);
    vecs[8]  = mk(1, 11, 5, 0, 0, 0, 8'h00,  0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h5B);
    vecs[9]  = mk(1, 3, 2, 0, 0, 0, 8'h00,   0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h5B);
    vecs[10] = mk(1, 3, 2, 0, 0, 0, 8'h00,   1, 0, 14'h103, 8'h00, 0, 0, 1, 8'h5B);
    vecs[11] = mk(1, 3, 2, 0, 0, 0, 8'h00,   0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h5B);
    vecs[12] = mk(1, 3, 2, 0, 0, 0, 8'h00,   0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h3C);
    vecs[13] = mk(1, 3, 2, 1, 0, 96, 8'hFF,  0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h3C);
    vecs[14] = mk(1, 3, 2, 1, 0, 96, 8'hFF,  0, 0, 14'h103, 8'h00, 1, 1, 1, 8'h3C);
    vecs[15] = mk(1, 3, 2, 1, 9, 9, 8'h5A,   0, 0, 14'h103, 8'h00, 0, 0, 1, 8'h3C);
    vecs[16] = mk(1, 3, 2, 1, 9, 9, 8'h5A,   1, 1, 14'h489, 8'h5A, 1, 0, 1, 8'h3C);
    vecs[17] = mk(1, 3, 2, 0, 0, 0, 8'h00,   0, 0, 14'h489, 8'h00, 0, 0, 1, 8'h3C);

    // Preload VRAM while reset is held.
    preload(14'h000, 8'h42);
    preload(14'h28A, 8'hA5);
    preload(14'h28B, 8'h5B);
    preload(14'h3000, 8'h11);
    preload(14'hA14, 8'h77);
    preload(14'h387, 8'hC7);
    @(negedge clk);
    checkAllZero("reset");

    // Start a write, then hit reset during its WRITE cycle.
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 1, 8'h99);
    @(negedge clk);
    checkOutput("pre-abort wr_ack", 32'(wr_ack), 32'd1);
    checkOutput("pre-abort ram_addr", 32'(ram_addr), 32'h081);
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    applyStimulus(0, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    checkAllZero("post-reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    checkOutput("first read ram_en", 32'(ram_en), 32'd1);
    checkOutput("first read ram_we", 32'(ram_we), 32'd0);
    checkOutput("first read ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    checkOutput("first read ram_en low", 32'(ram_en), 32'd0);
    @(negedge clk);
    checkOutput("first pixel_data", 32'(pixel_data), 32'h42);
    checkOutput("first pixel_valid", 32'(pixel_valid), 32'd1);
    checkOutput("aborted write mem", 32'(mem[14'h081]), 32'd0);

    // Table-driven fetch, collision and range vectors.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      checkOutput($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(vecs[i].e_en));
      checkOutput($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      if (vecs[i].e_en)
        checkOutput($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we)
        checkOutput($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wd));
      checkOutput($sformatf("v%0d wr_ack", i), 32'(wr_ack), 32'(vecs[i].e_ack));
      checkOutput($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vecs[i].e_err));
      checkOutput($sformatf("v%0d pixel_valid", i), 32'(pixel_valid), 32'(vecs[i].e_pv));
      checkOutput($sformatf("v%0d pixel_data", i), 32'(pixel_data), 32'(vecs[i].e_pd));
      applyStimulus(vecs[i].vo, vecs[i].x, vecs[i].y, vecs[i].req,
                    vecs[i].wx, vecs[i].wy, vecs[i].wd);
    end
    @(negedge clk);
    checkOutput("mem (9,9)", 32'(mem[14'h489]), 32'h5A);
    checkOutput("mem oob untouched", 32'(mem[14'h3000]), 32'h11);
    checkOutput("mem (3,2)", 32'(mem[14'h103]), 32'h3C);

    // Blanking: drop video_on the cycle after a READ; the capture is dropped.
    applyStimulus(1, 20, 20, 0, 0, 0, 8'h00);
    @(negedge clk);
    checkOutput("blank read ram_en", 32'(ram_en), 32'd1);
    checkOutput("blank read ram_addr", 32'(ram_addr), 32'hA14);
    @(negedge clk);
    applyStimulus(0, 20, 20, 0, 0, 0, 8'h00);
    @(negedge clk);
    checkOutput("blank pixel_data", 32'(pixel_data), 32'd0);
    checkOutput("blank pixel_valid", 32'(pixel_valid), 32'd0);

    // Continuous writer stream while blanked: one ack every 2 cycles.
    n = 0;
    applyStimulus(0, 0, 20, 1, 0, 50, 8'h40);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stream%0d wr_ack", k), 32'(wr_ack), 32'(k % 2));
      checkOutput($sformatf("stream%0d ram_we", k), 32'(ram_we), 32'(k % 2));
      checkOutput($sformatf("stream%0d read", k), 32'(ram_en && !ram_we), 32'd0);
      checkOutput($sformatf("stream%0d pixel_valid", k), 32'(pixel_valid), 32'd0);
      x_pixel = 7'(k);
      if (wr_ack) begin
        n++;
        if (n < 5) begin
          wr_x = 7'(n);
          wr_data = 8'h40 + 8'(n);
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    checkOutput("stream ack count", 32'(n), 32'd5);
    for (int j = 0; j < 5; j++)
      checkOutput($sformatf("stream mem %0d", j), 32'(mem[{7'd50, 7'(j)}]), 32'h40 + 32'(j));

    // Held coordinate: exactly one read for (7,7) across 20 cycles.
    reads = 0;
    @(negedge clk);
    applyStimulus(1, 7, 7, 0, 0, 0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_en && !ram_we) begin
        reads++;
        checkOutput("held read ram_addr", 32'(ram_addr), 32'h387);
      end
    end
    checkOutput("held read count", 32'(reads), 32'd1);
    checkOutput("held pixel_data", 32'(pixel_data), 32'hC7);
    checkOutput("held pixel_valid", 32'(pixel_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
